id_operand_ctrl: RTL and testbench
==================================

// Module: id_operand_ctrl
// PURPOSE
//  Decode-stage operand controller for the 16-bit pipeline. Tracks in-flight destinations in
//  EX and MEM, generates the src1 immediate/register select and forwarding selects for both
//  ALU sources, and sequences load-use stalls. Selects are registered to align with EX,
//  where the src1 immediate/register mux and forwarding muxes consume them.
// PARAMETERS
//  REG_W        4   register-specifier width (2**REG_W architectural regs; R0 reads as zero)
//  LOAD_STALL   1   bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk          in   1      pipeline clock, all state on rising edge
//  rst_n        in   1      asynchronous reset, active low
//  flush        in   1      branch/jump redirect: kill ID/EX/MEM tracking
//  id_valid     in   1      instruction present in ID
//  id_rs        in   REG_W  src0 register
//  id_rt        in   REG_W  src1 register
//  id_uses_rs   in   1      instruction reads rs
//  id_uses_rt   in   1      instruction reads rt as register (ignored if id_imm_op)
//  id_imm_op    in   1      src1 = sign-extended 8-bit immediate
//  id_we        in   1      instruction writes id_rd
//  id_rd        in   REG_W  destination register
//  id_is_load   in   1      instruction is a memory load
//  stall        out  1      hold PC and IF/ID (combinational)
//  ex_valid     out  1      EX holds a real instruction (registered)
//  ex_src1sel   out  1      src1 mux select in EX: 1=immediate, 0=register (registered)
//  ex_fwd0      out  2      src0 source in EX: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  ex_fwd1      out  2      src1 source in EX, same encoding; forced 00 when ex_src1sel=1
// BEHAVIOUR
//  Reset: stall=0, ex_valid=0, ex_src1sel=0, ex_fwd0=ex_fwd1=00, FSM=RUN, counter=0,
//   internal EX/MEM trackers {valid,we,rd,is_load} all 0.
//  Trackers: EX tracker = instruction now in EX; MEM tracker = instruction now in MEM.
//   Each edge MEM<=EX. EX<=ID fields when !stall && id_valid, else bubble (valid=0).
//  Forwarding (computed in ID from trackers, registered into ex_fwd*):
//   hit_ex(r)  = EX.valid & EX.we & !EX.is_load & EX.rd==r & r!=0
//   hit_mem(r) = MEM.valid & MEM.we & MEM.rd==r & r!=0
//   sel = hit_ex ? 01 : hit_mem ? 10 : 00  (EX priority over MEM on dual match)
//   src0 uses id_rs gated by id_uses_rs; src1 uses id_rt gated by id_uses_rt & !id_imm_op.
//  Load-use hazard: haz = id_valid & EX.valid & EX.is_load & EX.we & EX.rd!=0 &
//   ((id_uses_rs & EX.rd==id_rs) | (id_uses_rt & !id_imm_op & EX.rd==id_rt)).
//  FSM: RUN: stall=haz; haz -> STALL, cnt<=LOAD_STALL-1; ID held, bubble to EX.
//   STALL: stall=(cnt!=0); cnt decrements each cycle; cnt==0 -> RUN (stall=0 that cycle,
//   ID re-evaluated; load now in MEM so hit_mem forwards 10). With LOAD_STALL=1 STALL
//   state lasts 0 extra cycles: one bubble total. Load result forwards from MEM/WB only.
//  Latency: ID decision in cycle N appears on ex_* in N+1 alongside ex_valid.
//  Bubble: ex_valid=0, ex_src1sel=0, ex_fwd*=00.
//  flush: highest priority. Same cycle stall=0; next edge EX and MEM trackers invalid,
//   ex_valid=0, FSM=RUN, cnt=0. flush mid-STALL aborts the stall.
//  id_valid=0: no hazard, bubble into EX, FSM unaffected except RUN/STALL counting.
//  Async reset mid-stall returns all state to reset values immediately.
// TESTING
//  T1 ADD R3<=R1,R2 then SUB R4<=R3,R5 back-to-back -> SUB in EX: ex_fwd0=01, stall never 1.
//  T2 ADD R3; NOP; ADDI R6<=R3,#-4 -> ADDI in EX: ex_fwd0=10, ex_src1sel=1, ex_fwd1=00.
//  T3 LD R2 then ADD R7<=R2,R2 -> stall=1 exactly 1 cycle, one bubble (ex_valid=0), then ADD
//     in EX with ex_fwd0=ex_fwd1=10; LOAD_STALL=2 -> stall 2 cycles, 2 bubbles.
//  T4 Writes to R0 then reads R0 (incl. LD R0; use R0) -> fwd 00, no stall.
//  T5 ADD R3 in MEM and SUB R3 in EX, reader of R3 -> ex_fwd0=01 (EX priority).
//  T6 LD R2; use R2; assert flush during stall cycle -> stall drops same cycle, next cycle
//     ex_valid=0, FSM RUN; rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_operand_ctrl.sv
// Decode-stage operand controller: tracks EX/MEM destinations, registers forwarding and
// src1 immediate selects into EX, and sequences load-use stall bubbles.
module id_operand_ctrl #(
    parameter int unsigned REG_W      = 4,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_imm_op,
    input  logic             id_we,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_is_load,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_src1sel,
    output logic [1:0]       ex_fwd0,
    output logic [1:0]       ex_fwd1
);

    typedef enum logic {StRun, StStall} state_e;

    localparam logic [1:0] CntInit = 2'(LOAD_STALL - 1);

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic             ex_we_q, ex_ld_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             mem_v_q, mem_we_q;
    logic [REG_W-1:0] mem_rd_q;

    logic use_rs, use_rt;
    logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic ld_in_ex, haz, take;
    logic [1:0] fwd0, fwd1;

    always_comb begin
        use_rs = id_uses_rs & (id_rs != '0);
        use_rt = id_uses_rt & ~id_imm_op & (id_rt != '0);

        hit_ex_rs  = ex_valid & ex_we_q & ~ex_ld_q & (ex_rd_q == id_rs) & use_rs;
        hit_ex_rt  = ex_valid & ex_we_q & ~ex_ld_q & (ex_rd_q == id_rt) & use_rt;
        hit_mem_rs = mem_v_q & mem_we_q & (mem_rd_q == id_rs) & use_rs;
        hit_mem_rt = mem_v_q & mem_we_q & (mem_rd_q == id_rt) & use_rt;

        fwd0 = hit_ex_rs ? 2'b01 : (hit_mem_rs ? 2'b10 : 2'b00);
        fwd1 = hit_ex_rt ? 2'b01 : (hit_mem_rt ? 2'b10 : 2'b00);

        // R0 never matches: use_rs/use_rt already exclude it
        ld_in_ex = ex_valid & ex_ld_q & ex_we_q;
        haz      = id_valid & ld_in_ex &
                   (((ex_rd_q == id_rs) & use_rs) | ((ex_rd_q == id_rt) & use_rt));

        if (flush) begin
            stall = 1'b0;
        end else if (state_q == StRun) begin
            stall = haz;
        end else begin
            stall = (cnt_q != 2'd0);
        end

        take = id_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            cnt_q      <= 2'd0;
            ex_valid   <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_rd_q    <= '0;
            mem_v_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_rd_q   <= '0;
            ex_src1sel <= 1'b0;
            ex_fwd0    <= 2'b00;
            ex_fwd1    <= 2'b00;
        end else if (flush) begin
            state_q    <= StRun;
            cnt_q      <= 2'd0;
            ex_valid   <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_rd_q    <= '0;
            mem_v_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_rd_q   <= '0;
            ex_src1sel <= 1'b0;
            ex_fwd0    <= 2'b00;
            ex_fwd1    <= 2'b00;
        end else begin
            mem_v_q  <= ex_valid;
            mem_we_q <= ex_we_q;
            mem_rd_q <= ex_rd_q;
            if (take) begin
                ex_valid   <= 1'b1;
                ex_we_q    <= id_we;
                ex_ld_q    <= id_is_load;
                ex_rd_q    <= id_rd;
                ex_src1sel <= id_imm_op;
                ex_fwd0    <= fwd0;
                ex_fwd1    <= fwd1;
            end else begin
                ex_valid   <= 1'b0;
                ex_we_q    <= 1'b0;
                ex_ld_q    <= 1'b0;
                ex_rd_q    <= '0;
                ex_src1sel <= 1'b0;
                ex_fwd0    <= 2'b00;
                ex_fwd1    <= 2'b00;
            end
            unique case (state_q)
                StRun: begin
                    if (haz) begin
                        state_q <= StStall;
                        cnt_q   <= CntInit;
                    end
                end
                StStall: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_id_operand_ctrl.sv
// Directed bench for id_operand_ctrl: one instance with LOAD_STALL=1, one with LOAD_STALL=2.
module tb_id_operand_ctrl;

    logic       clk, rst_n, flush;
    logic       id_valid, id_uses_rs, id_uses_rt, id_imm_op, id_we, id_is_load;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       stall_a, ex_valid_a, ex_src1sel_a;
    logic [1:0] ex_fwd0_a, ex_fwd1_a;
    logic       stall_b, ex_valid_b, ex_src1sel_b;
    logic [1:0] ex_fwd0_b, ex_fwd1_b;

    int checks;
    int failures;

    id_operand_ctrl #(.REG_W(4), .LOAD_STALL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_imm_op(id_imm_op), .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
        .stall(stall_a), .ex_valid(ex_valid_a), .ex_src1sel(ex_src1sel_a),
        .ex_fwd0(ex_fwd0_a), .ex_fwd1(ex_fwd1_a)
    );

    id_operand_ctrl #(.REG_W(4), .LOAD_STALL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_imm_op(id_imm_op), .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
        .stall(stall_b), .ex_valid(ex_valid_b), .ex_src1sel(ex_src1sel_b),
        .ex_fwd0(ex_fwd0_b), .ex_fwd1(ex_fwd1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [3:0] rt, input logic urs, input logic urt,
                          input logic imm, input logic we, input logic ld);
        id_valid = v; id_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = urs;
        id_uses_rt = urt; id_imm_op = imm; id_we = we; id_is_load = ld;
    endtask

    task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        set_id(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // rt left flagged as used so the immediate gating of src1 forwarding is exercised
    task automatic addi(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        set_id(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic ld(input logic [3:0] rd, input logic [3:0] rs);
        set_id(1'b1, rd, rs, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        #12;
        chk("rst_stall", {1'b0, stall_a}, 2'b00);
        chk("rst_ex_valid", {1'b0, ex_valid_a}, 2'b00);
        chk("rst_src1sel", {1'b0, ex_src1sel_a}, 2'b00);
        chk("rst_fwd0", ex_fwd0_a, 2'b00);
        chk("rst_fwd1", ex_fwd1_b, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // T1: ADD R3<=R1,R2 ; SUB R4<=R3,R5
        alu(4'd3, 4'd1, 4'd2);
        @(negedge clk); chk("t1_add_stall", {1'b0, stall_a}, 2'b00);
        step();
        chk("t1_add_valid", {1'b0, ex_valid_a}, 2'b01);
        chk("t1_add_fwd0", ex_fwd0_a, 2'b00);
        alu(4'd4, 4'd3, 4'd5);
        @(negedge clk); chk("t1_sub_stall", {1'b0, stall_a}, 2'b00);
        step();
        chk("t1_sub_fwd0", ex_fwd0_a, 2'b01);
        chk("t1_sub_fwd1", ex_fwd1_a, 2'b00);

        // T2: ADD R3 ; NOP ; ADDI R6<=R3,#imm
        alu(4'd3, 4'd1, 4'd2);
        step();
        idle();
        step();
        chk("t2_bubble_valid", {1'b0, ex_valid_a}, 2'b00);
        addi(4'd6, 4'd3, 4'd3);
        step();
        chk("t2_addi_valid", {1'b0, ex_valid_a}, 2'b01);
        chk("t2_addi_fwd0", ex_fwd0_a, 2'b10);
        chk("t2_addi_src1sel", {1'b0, ex_src1sel_a}, 2'b01);
        chk("t2_addi_fwd1", ex_fwd1_a, 2'b00);

        // T5: ADD R3 ; SUB R3 ; reader of R3 sees EX over MEM
        alu(4'd3, 4'd1, 4'd2);
        step();
        alu(4'd3, 4'd3, 4'd4);
        step();
        chk("t5_sub_fwd0", ex_fwd0_a, 2'b01);
        alu(4'd5, 4'd3, 4'd3);
        step();
        chk("t5_prio_fwd0", ex_fwd0_a, 2'b01);
        chk("t5_prio_fwd1", ex_fwd1_a, 2'b01);

        // T4: R0 writes never forward and LD R0 never stalls
        alu(4'd0, 4'd1, 4'd2);
        step();
        alu(4'd5, 4'd0, 4'd0);
        step();
        chk("t4_r0_fwd0", ex_fwd0_a, 2'b00);
        chk("t4_r0_fwd1", ex_fwd1_a, 2'b00);
        ld(4'd0, 4'd1);
        step();
        alu(4'd5, 4'd0, 4'd0);
        @(negedge clk); chk("t4_ldr0_stall", {1'b0, stall_a}, 2'b00);
        step();
        chk("t4_ldr0_valid", {1'b0, ex_valid_a}, 2'b01);
        chk("t4_ldr0_fwd0", ex_fwd0_a, 2'b00);

        // T3: LD R2 ; ADD R7<=R2,R2
        ld(4'd2, 4'd1);
        @(negedge clk); chk("t3_ld_stall", {1'b0, stall_a}, 2'b00);
        step();
        chk("t3_ld_src1sel", {1'b0, ex_src1sel_a}, 2'b01);
        alu(4'd7, 4'd2, 4'd2);
        @(negedge clk);
        chk("t3_stall1_a", {1'b0, stall_a}, 2'b01);
        chk("t3_stall1_b", {1'b0, stall_b}, 2'b01);
        step();
        chk("t3_bubble_a", {1'b0, ex_valid_a}, 2'b00);
        chk("t3_bubble1_b", {1'b0, ex_valid_b}, 2'b00);
        @(negedge clk);
        chk("t3_stall2_a", {1'b0, stall_a}, 2'b00);
        chk("t3_stall2_b", {1'b0, stall_b}, 2'b01);
        step();
        chk("t3_add_valid_a", {1'b0, ex_valid_a}, 2'b01);
        chk("t3_add_fwd0_a", ex_fwd0_a, 2'b10);
        chk("t3_add_fwd1_a", ex_fwd1_a, 2'b10);
        chk("t3_bubble2_b", {1'b0, ex_valid_b}, 2'b00);
        @(negedge clk);
        chk("t3_stall3_b", {1'b0, stall_b}, 2'b00);
        step();
        chk("t3_add_valid_b", {1'b0, ex_valid_b}, 2'b01);
        chk("t3_add_fwd0_b", ex_fwd0_b, 2'b00);

        // T6a: flush during the load-use stall cycle
        ld(4'd2, 4'd1);
        step();
        alu(4'd7, 4'd2, 4'd2);
        @(negedge clk);
        chk("t6_pre_stall", {1'b0, stall_a}, 2'b01);
        flush = 1'b1;
        #1;
        chk("t6_flush_stall_a", {1'b0, stall_a}, 2'b00);
        chk("t6_flush_stall_b", {1'b0, stall_b}, 2'b00);
        step();
        chk("t6_flush_valid_a", {1'b0, ex_valid_a}, 2'b00);
        chk("t6_flush_valid_b", {1'b0, ex_valid_b}, 2'b00);
        flush = 1'b0;
        @(negedge clk);
        chk("t6_after_stall_a", {1'b0, stall_a}, 2'b00);
        chk("t6_after_stall_b", {1'b0, stall_b}, 2'b00);
        step();
        chk("t6_after_valid", {1'b0, ex_valid_a}, 2'b01);
        chk("t6_after_fwd0", ex_fwd0_a, 2'b00);

        // T6b: flush aborts a multi-cycle stall
        ld(4'd2, 4'd1);
        step();
        alu(4'd7, 4'd2, 4'd2);
        step();
        @(negedge clk);
        chk("t6b_mid_stall_b", {1'b0, stall_b}, 2'b01);
        flush = 1'b1;
        #1;
        chk("t6b_flush_stall_b", {1'b0, stall_b}, 2'b00);
        step();
        chk("t6b_flush_valid_a", {1'b0, ex_valid_a}, 2'b00);
        chk("t6b_flush_valid_b", {1'b0, ex_valid_b}, 2'b00);
        flush = 1'b0;

        // T6c: asynchronous reset during a stall
        ld(4'd2, 4'd1);
        step();
        alu(4'd7, 4'd2, 4'd2);
        @(negedge clk);
        chk("t6c_pre_stall", {1'b0, stall_a}, 2'b01);
        chk("t6c_pre_src1sel", {1'b0, ex_src1sel_a}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("t6c_rst_stall", {1'b0, stall_a}, 2'b00);
        chk("t6c_rst_valid", {1'b0, ex_valid_a}, 2'b00);
        chk("t6c_rst_src1sel", {1'b0, ex_src1sel_a}, 2'b00);
        chk("t6c_rst_stall_b", {1'b0, stall_b}, 2'b00);
        chk("t6c_rst_fwd0_b", ex_fwd0_b, 2'b00);
        #1;
        rst_n = 1'b1;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
